// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch state encoding for the MIPS core
package mips_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    BLOCKED,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry instruction+pc holding buffer for the fetch stage
module fetch_skid_buf
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_full,
  output logic [31:0]     o_instr,
  output logic [PC_W-1:0] o_pc
);

  logic            r_full;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;

  // Clear wins over load so a redirect always leaves the buffer empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_instr <= NOP_WORD;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem req/ready handshake, output register, skid, redirect
module instr_fetch
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] instr_pc4
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  fetch_state_t    r_state, w_next_state;
  logic [PC_W-1:0] r_pc, w_pc_next, r_hold_addr, w_target;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic [PC_W-1:0] r_instr_pc, r_instr_pc4;

  logic            w_consume, w_slot_free;
  logic            w_out_load, w_out_flush, w_out_drop, w_from_skid;
  logic            w_skid_load, w_skid_drain, w_skid_clear, w_hold_load;
  logic            w_skid_full;
  logic [31:0]     w_skid_instr, w_src_instr;
  logic [PC_W-1:0] w_skid_pc, w_src_pc;

  assign w_consume   = r_valid && !stall;
  assign w_slot_free = !r_valid || !stall;
  assign w_target    = redirect_pc & ~PC_W'(3);

  // DISCARD keeps presenting the abandoned address while r_pc already holds the target.
  assign imem_req  = (r_state == FETCH) || (r_state == DISCARD);
  assign imem_addr = (r_state == DISCARD) ? r_hold_addr : r_pc;

  assign w_src_instr = w_from_skid ? w_skid_instr : imem_rdata;
  assign w_src_pc    = w_from_skid ? w_skid_pc : r_pc;

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (w_skid_clear),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .o_full  (w_skid_full),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_out_load   = 1'b0;
    w_out_flush  = 1'b0;
    w_out_drop   = 1'b0;
    w_from_skid  = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_drain = 1'b0;
    w_skid_clear = 1'b0;
    w_hold_load  = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = FETCH;
        if (redirect) w_pc_next = w_target;
      end
      FETCH: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_out_flush  = 1'b1;
          w_skid_clear = 1'b1;
          if (!imem_ready) begin
            w_next_state = DISCARD;
            w_hold_load  = 1'b1;
          end
        end else if (imem_ready) begin
          w_pc_next = r_pc + PC_STEP;
          if (w_slot_free) begin
            w_out_load = 1'b1;
          end else begin
            w_skid_load  = 1'b1;
            w_next_state = BLOCKED;
          end
        end else if (w_consume) begin
          w_out_drop = 1'b1;
        end
      end
      BLOCKED: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_out_flush  = 1'b1;
          w_skid_clear = 1'b1;
          w_next_state = FETCH;
        end else if (w_consume && w_skid_full) begin
          w_skid_drain = 1'b1;
          w_out_load   = 1'b1;
          w_from_skid  = 1'b1;
          w_next_state = FETCH;
        end
      end
      DISCARD: begin
        if (redirect) begin
          w_pc_next    = w_target;
          w_out_flush  = 1'b1;
          w_skid_clear = 1'b1;
        end
        if (imem_ready) w_next_state = FETCH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_hold_addr <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_hold_load) r_hold_addr <= r_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr     <= NOP_WORD;
      r_valid     <= 1'b0;
      r_instr_pc  <= RESET_PC;
      r_instr_pc4 <= RESET_PC + PC_STEP;
    end else if (w_out_flush) begin
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
    end else if (w_out_load) begin
      r_instr     <= w_src_instr;
      r_valid     <= 1'b1;
      r_instr_pc  <= w_src_pc;
      r_instr_pc4 <= w_src_pc + PC_STEP;
    end else if (w_out_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign instr_pc    = r_instr_pc;
  assign instr_pc4   = r_instr_pc4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with a program-order scoreboard
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  logic [31:0] imem_addr_w;
  logic        imem_req_w;
  logic        imem_ready_w = 1'b1;
  logic [31:0] imem_rdata_w = 32'h0;
  logic        stall_w = 1'b0;
  logic        redirect_w = 1'b0;
  logic [31:0] redirect_pc_w = 32'h0;
  logic [31:0] instr_w;
  logic        instr_valid_w;
  logic [31:0] instr_pc_w;
  logic [31:0] instr_pc4_w;

  int          total = 0;
  int          bad = 0;
  int          mem_delay = 0;
  int          waited = 0;
  logic [31:0] salt = 32'h0;
  logic [31:0] exp_pc = 32'h0;

  instr_fetch #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .instr_pc4(instr_pc4)
  );

  instr_fetch #(.PC_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_w), .imem_req(imem_req_w),
    .imem_ready(imem_ready_w), .imem_rdata(imem_rdata_w), .stall(stall_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w), .instr(instr_w),
    .instr_valid(instr_valid_w), .instr_pc(instr_pc_w), .instr_pc4(instr_pc4_w)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Instruction memory: answers after mem_delay wait cycles, data is a function of address.
  initial begin
    forever begin
      @(negedge clk);
      imem_rdata   = mem_word(imem_addr);
      imem_rdata_w = imem_addr_w;
      if (imem_req) begin
        imem_ready = (waited >= mem_delay);
        if (imem_ready) waited = 0;
        else waited++;
      end else begin
        imem_ready = 1'b0;
        waited     = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    exp_pc = 32'h0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%h want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
    total++; if (instr_pc4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h want=4", instr_pc4); end
    total++; if (instr_pc_w !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_pc_wrap got=%h want=fffffff8", instr_pc_w); end
    total++; if (instr_pc4_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_pc4_wrap got=%h want=fffffffc", instr_pc4_w); end
  endtask

  task automatic test_stream();
    salt = 32'h0; mem_delay = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid got=%h want=0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stream_c1_req got=%h/%h want=1/0", imem_req, imem_addr); end
      end else begin
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid c=%0d got=%h want=1", c, instr_valid); end
        total++; if (instr_pc !== 32'(4 * (c - 2))) begin bad++; $display("FAIL stream_pc got=%h want=%h", instr_pc, 32'(4 * (c - 2))); end
        total++; if (instr !== mem_word(32'(4 * (c - 2)))) begin bad++; $display("FAIL stream_instr got=%h want=%h", instr, mem_word(32'(4 * (c - 2)))); end
        total++; if (instr_pc4 !== 32'(4 * (c - 1))) begin bad++; $display("FAIL stream_pc4 got=%h want=%h", instr_pc4, 32'(4 * (c - 1))); end
      end
    end
  endtask

  task automatic test_stall();
    int k;
    bit done;
    salt = $urandom; mem_delay = 0;
    do_reset();
    k = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk); #1;
      if (k == 0 && instr_valid && instr_pc == 32'h10) k = 1;
      else if (k > 0 && k < 4) k++;
      stall = (k >= 1 && k <= 3);
      if (k == 2 || k == 3) begin
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_blocked_req got=%h want=0", imem_req); end
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10) begin bad++; $display("FAIL stall_hold got=%h/%h want=1/10", instr_valid, instr_pc); end
      end
      if (instr_valid && !stall) begin
        total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL stall_order got=%h want=%h", instr_pc, exp_pc); end
        total++; if (instr !== mem_word(exp_pc)) begin bad++; $display("FAIL stall_data got=%h want=%h", instr, mem_word(exp_pc)); end
        if (k != 0 && instr_pc == 32'h18) done = 1'b1;
        exp_pc += 32'd4;
      end
    end
    stall = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL stall_timeout got=%0d want=1", done); end
  endtask

  task automatic test_redirect_pending();
    bit seen_ready, chk_next, got;
    salt = $urandom; mem_delay = 3;
    do_reset();
    seen_ready = 1'b0; chk_next = 1'b0; got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rp_first got=%h/%h want=1/0", imem_req, imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h0000_0400; exp_pc = 32'h400;
      end else begin
        redirect = 1'b0;
        if (!seen_ready) begin
          total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL rp_hold got=%h/%h want=1/0", imem_req, imem_addr); end
          if (imem_ready) begin seen_ready = 1'b1; chk_next = 1'b1; end
        end else if (chk_next) begin
          chk_next = 1'b0;
          total++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin bad++; $display("FAIL rp_next_addr got=%h/%h want=1/400", imem_req, imem_addr); end
        end
        if (instr_valid) begin
          got = 1'b1;
          total++; if (instr_pc !== 32'h400) begin bad++; $display("FAIL rp_first_pc got=%h want=400", instr_pc); end
          total++; if (instr !== mem_word(32'h400)) begin bad++; $display("FAIL rp_first_instr got=%h want=%h", instr, mem_word(32'h400)); end
        end
      end
    end
    redirect = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL rp_timeout got=%0d want=1", got); end
  endtask

  task automatic test_redirect_with_ready();
    salt = $urandom; mem_delay = 0;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      redirect = 1'b0;
      if (c >= 2 && c <= 5) begin
        total++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin bad++; $display("FAIL rr_pre got=%h/%h want=1/%h", instr_valid, instr_pc, exp_pc); end
        exp_pc += 32'd4;
      end
      if (c == 5) begin redirect = 1'b1; redirect_pc = 32'h0000_0203; exp_pc = 32'h200; end
      if (c == 6) begin
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rr_flush got=%h want=0", instr_valid); end
        total++; if (imem_addr !== 32'h200) begin bad++; $display("FAIL rr_addr got=%h want=200", imem_addr); end
      end
      if (c == 7) begin
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin bad++; $display("FAIL rr_target got=%h/%h want=1/200", instr_valid, instr_pc); end
        total++; if (instr !== mem_word(32'h200)) begin bad++; $display("FAIL rr_instr got=%h want=%h", instr, mem_word(32'h200)); end
        total++; if (instr_pc4 !== 32'h204) begin bad++; $display("FAIL rr_pc4 got=%h want=204", instr_pc4); end
      end
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      if (c == 2) begin
        total++; if (instr_valid_w !== 1'b1 || instr_pc_w !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_c2 got=%h/%h want=1/fffffff8", instr_valid_w, instr_pc_w); end
        total++; if (imem_req_w !== 1'b1) begin bad++; $display("FAIL wrap_req got=%h want=1", imem_req_w); end
      end
      if (c == 3) begin
        total++; if (instr_pc_w !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_c3 got=%h want=fffffffc", instr_pc_w); end
        total++; if (instr_pc4_w !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h want=0", instr_pc4_w); end
      end
      if (c == 4) begin
        total++; if (instr_pc_w !== 32'h0 || instr_w !== 32'h0) begin bad++; $display("FAIL wrap_c4 got=%h/%h want=0/0", instr_pc_w, instr_w); end
        total++; if (instr_pc4_w !== 32'h4) begin bad++; $display("FAIL wrap_c4_pc4 got=%h want=4", instr_pc4_w); end
      end
    end
  endtask

  task automatic test_async_reset();
    salt = $urandom; mem_delay = 0;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      stall = (c >= 4);
    end
    total++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL ar_pre got=%h/%h want=1/0", instr_valid, imem_req); end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin bad++; $display("FAIL ar_out got=%h/%h want=0/0", instr_valid, instr); end
    total++; if (instr_pc !== 32'h0 || instr_pc4 !== 32'h4) begin bad++; $display("FAIL ar_pc got=%h/%h want=0/4", instr_pc, instr_pc4); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ar_req got=%h want=0", imem_req); end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; exp_pc = 32'h0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL ar_restart_addr got=%h/%h want=0/0", instr_valid, imem_addr); end
      end else begin
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL ar_restart_pc got=%h/%h want=1/0", instr_valid, instr_pc); end
        total++; if (instr !== mem_word(32'h0)) begin bad++; $display("FAIL ar_restart_instr got=%h want=%h", instr, mem_word(32'h0)); end
      end
    end
  endtask

  task automatic test_random();
    bit          prev_pending;
    logic [31:0] prev_addr;
    int          consumed;
    for (int d = 0; d < 3; d++) begin
      salt = $urandom; mem_delay = d;
      do_reset();
      prev_pending = 1'b0; prev_addr = 32'h0; consumed = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk); #1;
        total++; if (imem_addr[1:0] !== 2'b00) begin bad++; $display("FAIL rnd_align got=%h want=0", imem_addr[1:0]); end
        if (imem_req && prev_pending) begin
          total++; if (imem_addr !== prev_addr) begin bad++; $display("FAIL rnd_addr_stable got=%h want=%h", imem_addr, prev_addr); end
        end
        prev_pending = imem_req && !imem_ready;
        prev_addr    = imem_addr;
        stall        = ($urandom_range(0, 99) < 35);
        redirect     = ($urandom_range(0, 99) < 6);
        redirect_pc  = $urandom;
        if (instr_valid && !stall) begin
          total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc got=%h want=%h", instr_pc, exp_pc); end
          total++; if (instr !== mem_word(exp_pc)) begin bad++; $display("FAIL rnd_instr got=%h want=%h", instr, mem_word(exp_pc)); end
          total++; if (instr_pc4 !== exp_pc + 32'd4) begin bad++; $display("FAIL rnd_pc4 got=%h want=%h", instr_pc4, exp_pc + 32'd4); end
          exp_pc += 32'd4;
          consumed++;
        end
        if (redirect) exp_pc = redirect_pc & ~32'h3;
      end
      stall = 1'b0; redirect = 1'b0;
      total++; if (consumed < 30) begin bad++; $display("FAIL rnd_progress got=%0d want>=30", consumed); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_pending();
    test_redirect_with_ready();
    test_pc_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the MIPS core; sits directly upstream of the instruction field splitter and drives its 32-bit instruction input.
- Owns the PC, issues word reads to instruction memory over a req/ready handshake, and holds the fetched instruction in an output register with a valid flag.
- Absorbs downstream stalls through a one-entry skid buffer.
- Accepts branch/jump redirects, which flush in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
PC_W, 32, PC and memory address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  PC_W  word address to instruction memory; [1:0] always 00
imem_req  out  1  read request
imem_ready  in  1  read data valid and handshake complete
imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
stall  in  1  downstream cannot accept instr this cycle
redirect  in  1  load redirect_pc, flush fetch path
redirect_pc  in  PC_W  branch/jump target; bits [1:0] ignored
instr  out  32  instruction to field splitter
instr_valid  out  1  instr holds a real instruction
instr_pc  out  PC_W  address of instr
instr_pc4  out  PC_W  instr_pc + 4, for link/branch adders

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=IDLE.
  - instr=32'h0000_0000 (NOP), instr_valid=0, instr_pc=RESET_PC, instr_pc4=RESET_PC+4.
  - skid empty, imem_req=0.
- Reset asserted mid-transaction abandons the request; memory side must tolerate req dropping.
- Consume event: instr_valid && !stall. Output slot free: !instr_valid || !stall.
- States:
  - IDLE: one cycle after reset release; go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Once req is high, addr and req stay stable until imem_ready.
  - BLOCKED: imem_req=0; entered when skid is full; leave to FETCH when skid drains.
  - DISCARD: imem_req=1, addr held; entered on redirect while a request is pending without ready. Data is dropped on ready, then FETCH at the new pc.
- FETCH, ready seen, no redirect:
  - pc <= pc+4, with 32-bit wrap: FFFF_FFFC -> 0000_0000.
  - If slot free: instr/instr_pc/instr_pc4 load and instr_valid=1; stay FETCH.
  - Else: data and its pc go to skid; go BLOCKED.
- FETCH, no ready: if a consume happens, instr_valid <= 0 unless skid supplies.
- Skid drain: on a consume while skid is full, skid moves to the output register and skid empties. It has priority over new memory data; memory data cannot arrive in the same cycle, since req=0 in BLOCKED.
- Redirect (highest priority, any state except IDLE):
  - pc <= {redirect_pc[PC_W-1:2],2'b00}.
  - instr_valid <= 0, instr <= 0, skid cleared.
  - Ready in the same cycle: data dropped, next state FETCH.
  - Request pending without ready: next state DISCARD.
  - BLOCKED/FETCH before issue: next state FETCH.
  - Redirect during DISCARD overwrites pc again and stays in DISCARD.
- Redirect in the IDLE cycle: pc loaded, state proceeds to FETCH.
- Latency:
  - Zero-wait memory (ready in the same cycle as req) gives one instruction per cycle.
  - First instr_valid appears 2 cycles after reset release.
  - Redirect to first valid target instruction: 2 cycles with zero-wait memory.
- Never more than one outstanding request. instr_valid drops only via consume-without-refill or redirect.

Decomposition:
Shared package mips_pkg holds:
- NOP word 32'h0000_0000.
- Fetch state encoding: IDLE, FETCH, BLOCKED, DISCARD.
- PC increment constant 4.

Natural sub-module: fetch_skid_buf, a one-entry instr+pc buffer with load/drain/clear. All else stays in instr_fetch.

Test Plan:
1. Reset release, zero-wait memory returning addr-as-data: instr_valid rises cycle 2; instr_pc sequence 0,4,8,C on consecutive cycles; instr_pc4 = instr_pc+4.
2. stall held 3 cycles while data returns: one word lands in skid, imem_req=0 during BLOCKED, no word lost or duplicated. After release, words appear in order 0x10, 0x14, 0x18.
3. Memory with 3-cycle ready delay plus redirect to 0x0000_0400 in the first wait cycle: imem_addr stays stable until ready, data discarded, next imem_addr = 0x400, instr_pc = 0x400 first.
4. Redirect and imem_ready in the same cycle with redirect_pc=0x0000_0203: returned word dropped, instr_valid=0 next cycle, next address 0x200.
5. PC wrap, RESET_PC=0xFFFF_FFF8: instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000; instr_pc4 of 0xFFFF_FFFC is 0.
6. Async reset asserted mid-FETCH with skid full: outputs go to reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
